// File: rtl/control_decoder_if.sv
// Control bundle between program memory / datapath and control_decoder.
// The master drives opcode, switch and ALU flags; the slave (decoder) drives the controls.
interface control_decoder_if #(
    parameter int unsigned OSize = 6,
    parameter int unsigned ASize = 3,
    parameter int unsigned FSize = 4
) ();
    logic [OSize-1:0] op_code;
    logic             demo_switch;
    logic [FSize-1:0] alu_flags;
    logic [ASize-1:0] alu_func;
    logic             alu_immediate;
    logic             imm_switches;
    logic             pc_inc;
    logic             pc_branch_abs;
    logic             pc_branch_rel;
    logic             write_reg;
    logic [FSize-1:0] flags;
    logic             busy;

    modport master (
        output op_code,
        output demo_switch,
        output alu_flags,
        input  alu_func,
        input  alu_immediate,
        input  imm_switches,
        input  pc_inc,
        input  pc_branch_abs,
        input  pc_branch_rel,
        input  write_reg,
        input  flags,
        input  busy
    );

    modport slave (
        input  op_code,
        input  demo_switch,
        input  alu_flags,
        output alu_func,
        output alu_immediate,
        output imm_switches,
        output pc_inc,
        output pc_branch_abs,
        output pc_branch_rel,
        output write_reg,
        output flags,
        output busy
    );
endinterface

// File: rtl/control_decoder.sv
// picoMIPS control decoder: opcode decode plus a small FSM for MUL stalls, WAIT and HALT.
// Owns the registered ALU flag set used by the conditional branches.
module control_decoder #(
    parameter int unsigned OSize      = 6,
    parameter int unsigned ASize      = 3,
    parameter int unsigned FSize      = 4,
    parameter int unsigned MulCycles  = 2,
    parameter int unsigned SyncStages = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    control_decoder_if.slave bus
);

    localparam logic [OSize-1:0] OpNop   = OSize'(0);
    localparam logic [OSize-1:0] OpAdd   = OSize'(1);
    localparam logic [OSize-1:0] OpAddi  = OSize'(2);
    localparam logic [OSize-1:0] OpMul   = OSize'(3);
    localparam logic [OSize-1:0] OpLdi   = OSize'(4);
    localparam logic [OSize-1:0] OpLds   = OSize'(5);
    localparam logic [OSize-1:0] OpWait0 = OSize'(6);
    localparam logic [OSize-1:0] OpWait1 = OSize'(7);
    localparam logic [OSize-1:0] OpBeq   = OSize'(8);
    localparam logic [OSize-1:0] OpBne   = OSize'(9);
    localparam logic [OSize-1:0] OpJmp   = OSize'(10);
    localparam logic [OSize-1:0] OpHalt  = OSize'(11);

    localparam logic [ASize-1:0] AluA   = ASize'(0);
    localparam logic [ASize-1:0] AluB   = ASize'(1);
    localparam logic [ASize-1:0] AluAdd = ASize'(2);
    localparam logic [ASize-1:0] AluMul = ASize'(3);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StMulBusy = 2'd1;
    localparam logic [1:0] StWait    = 2'd2;
    localparam logic [1:0] StHalted  = 2'd3;

    localparam int unsigned CntW = (MulCycles > 1) ? $clog2(MulCycles) : 1;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       mul_cnt_q, mul_cnt_d;
    logic [FSize-1:0]      flags_q, flags_d;
    logic [SyncStages-1:0] sync_q;
    logic                  sw_sync;

    logic [ASize-1:0] alu_func_dec;
    logic             alu_imm_dec;
    logic             imm_sw_dec;
    logic             pc_inc_dec;
    logic             pc_abs_dec;
    logic             pc_rel_dec;
    logic             write_reg_dec;
    logic             busy_dec;

    assign sw_sync = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], bus.demo_switch};
        end
    end

    always_comb begin
        alu_func_dec  = AluA;
        alu_imm_dec   = 1'b0;
        imm_sw_dec    = 1'b0;
        pc_inc_dec    = 1'b1;
        pc_abs_dec    = 1'b0;
        pc_rel_dec    = 1'b0;
        write_reg_dec = 1'b1;
        busy_dec      = 1'b0;
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;

        case (state_q)
            // WAIT re-decodes the held opcode; it only differs from RUN in the busy history.
            StRun, StWait: begin
                state_d = StRun;
                case (bus.op_code)
                    OpNop: ;
                    OpLdi: begin
                        alu_func_dec = AluB;
                        alu_imm_dec  = 1'b1;
                    end
                    OpLds: begin
                        alu_func_dec = AluB;
                        alu_imm_dec  = 1'b1;
                        imm_sw_dec   = 1'b1;
                    end
                    OpAdd: alu_func_dec = AluAdd;
                    OpAddi: begin
                        alu_func_dec = AluAdd;
                        alu_imm_dec  = 1'b1;
                    end
                    OpJmp: begin
                        pc_abs_dec    = 1'b1;
                        pc_inc_dec    = 1'b0;
                        write_reg_dec = 1'b0;
                    end
                    OpBeq, OpBne: begin
                        write_reg_dec = 1'b0;
                        if (flags_q[0] == (bus.op_code == OpBeq)) begin
                            pc_rel_dec = 1'b1;
                            pc_inc_dec = 1'b0;
                        end
                    end
                    OpMul: begin
                        alu_func_dec = AluMul;
                        if (MulCycles > 1) begin
                            pc_inc_dec    = 1'b0;
                            write_reg_dec = 1'b0;
                            busy_dec      = 1'b1;
                            state_d       = StMulBusy;
                            mul_cnt_d     = CntW'(MulCycles - 1);
                        end
                    end
                    OpWait0, OpWait1: begin
                        if (sw_sync != (bus.op_code == OpWait1)) begin
                            pc_inc_dec    = 1'b0;
                            write_reg_dec = 1'b0;
                            busy_dec      = 1'b1;
                            state_d       = StWait;
                        end
                    end
                    OpHalt: begin
                        pc_inc_dec    = 1'b0;
                        write_reg_dec = 1'b0;
                        busy_dec      = 1'b1;
                        state_d       = StHalted;
                    end
                    default: ;
                endcase
            end
            // The opcode is ignored here; the single write lands on the last count.
            StMulBusy: begin
                alu_func_dec = AluMul;
                busy_dec     = 1'b1;
                mul_cnt_d    = mul_cnt_q - 1'b1;
                if (mul_cnt_q == CntW'(1)) begin
                    state_d = StRun;
                end else begin
                    pc_inc_dec    = 1'b0;
                    write_reg_dec = 1'b0;
                end
            end
            default: begin
                pc_inc_dec    = 1'b0;
                write_reg_dec = 1'b0;
                busy_dec      = 1'b1;
            end
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (write_reg_dec && (alu_func_dec == AluAdd || alu_func_dec == AluMul)) begin
            flags_d = bus.alu_flags;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            mul_cnt_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            flags_q   <= flags_d;
        end
    end

    // Outputs are held quiet while reset is asserted, independent of the clock.
    assign bus.alu_func      = rst_ni ? alu_func_dec : AluA;
    assign bus.alu_immediate = rst_ni & alu_imm_dec;
    assign bus.imm_switches  = rst_ni & imm_sw_dec;
    assign bus.pc_inc        = rst_ni & pc_inc_dec;
    assign bus.pc_branch_abs = rst_ni & pc_abs_dec;
    assign bus.pc_branch_rel = rst_ni & pc_rel_dec;
    assign bus.write_reg     = rst_ni & write_reg_dec;
    assign bus.busy          = rst_ni & busy_dec;
    assign bus.flags         = flags_q;

    a_pc_onehot: assert property (@(posedge clk_i)
        $onehot0({bus.pc_inc, bus.pc_branch_abs, bus.pc_branch_rel}));

    a_halt_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == StHalted |=> state_q == StHalted);

    a_mul_cnt_live: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == StMulBusy |-> mul_cnt_q != '0);

endmodule

// File: tb/tb_control_decoder.sv
// Scoreboard bench for control_decoder: three instances cover MUL latencies of 1, 3 and 4.
module tb_control_decoder;

    localparam int unsigned Sync = 2;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd3;
    localparam logic [5:0] OP_LDI   = 6'd4;
    localparam logic [5:0] OP_LDS   = 6'd5;
    localparam logic [5:0] OP_WAIT0 = 6'd6;
    localparam logic [5:0] OP_WAIT1 = 6'd7;
    localparam logic [5:0] OP_BEQ   = 6'd8;
    localparam logic [5:0] OP_BNE   = 6'd9;
    localparam logic [5:0] OP_JMP   = 6'd10;
    localparam logic [5:0] OP_HALT  = 6'd11;

    localparam logic [2:0] ALU_A   = 3'd0;
    localparam logic [2:0] ALU_B   = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;

    // {alu[2:0], imm, isw, inc, abs, rel, wr, busy, flags[3:0]}
    typedef logic [13:0] vec_t;
    typedef struct {
        string name;
        vec_t  v;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = OP_NOP;
    logic       sw = 1'b0;
    logic [3:0] aluf = 4'd0;
    logic [3:0] flags_m = 4'd0;

    always #5 clk = ~clk;

    control_decoder_if #(.OSize(6), .ASize(3), .FSize(4)) if1 ();
    control_decoder_if #(.OSize(6), .ASize(3), .FSize(4)) if3 ();
    control_decoder_if #(.OSize(6), .ASize(3), .FSize(4)) if4 ();

    assign if1.op_code = op;
    assign if1.demo_switch = sw;
    assign if1.alu_flags = aluf;
    assign if3.op_code = op;
    assign if3.demo_switch = sw;
    assign if3.alu_flags = aluf;
    assign if4.op_code = op;
    assign if4.demo_switch = sw;
    assign if4.alu_flags = aluf;

    control_decoder #(.MulCycles(1), .SyncStages(Sync)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1));
    control_decoder #(.MulCycles(3), .SyncStages(Sync)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if3));
    control_decoder #(.MulCycles(4), .SyncStages(Sync)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if4));

    function automatic logic [9:0] ex(input logic [2:0] a, input logic imm, input logic isw,
                                      input logic inc, input logic ab, input logic rel,
                                      input logic wr, input logic busy);
        return {a, imm, isw, inc, ab, rel, wr, busy};
    endfunction

    function automatic vec_t obs(input int which);
        case (which)
            1: return {if1.alu_func, if1.alu_immediate, if1.imm_switches, if1.pc_inc,
                       if1.pc_branch_abs, if1.pc_branch_rel, if1.write_reg, if1.busy, if1.flags};
            4: return {if4.alu_func, if4.alu_immediate, if4.imm_switches, if4.pc_inc,
                       if4.pc_branch_abs, if4.pc_branch_rel, if4.write_reg, if4.busy, if4.flags};
            default: return {if3.alu_func, if3.alu_immediate, if3.imm_switches, if3.pc_inc,
                       if3.pc_branch_abs, if3.pc_branch_rel, if3.write_reg, if3.busy, if3.flags};
        endcase
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs; flags_m tracks the flag register.
    task automatic drive(input string nm, input logic [5:0] o, input logic [3:0] af,
                         input logic s, input logic [9:0] e10);
        exp_t it;
        @(posedge clk);
        #1;
        op = o;
        aluf = af;
        sw = s;
        it.name = nm;
        it.v = {e10, flags_m};
        sb.push_back(it);
        if (e10[1] && (e10[9:7] == ALU_ADD || e10[9:7] == ALU_MUL)) flags_m = af;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        op = OP_NOP;
        sw = 1'b0;
        aluf = 4'd0;
        flags_m = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t it;
        vec_t got;
        op = OP_ADD;
        aluf = 4'hF;
        for (int w = 1; w <= 4; w++) begin
            if (w == 2) continue;
            it.name = $sformatf("reset_dut%0d", w);
            it.v = '0;
            sb.push_back(it);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(w);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
        apply_reset();
    endtask

    task automatic test_flags_branch();
        logic [5:0] ops[7] = '{OP_ADDI, OP_BEQ, OP_BNE, OP_ADD, OP_BNE, OP_LDI, OP_BEQ};
        logic [3:0] afs[7] = '{4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b0001, 4'b1111, 4'b1111};
        logic [9:0] exps[7] = '{
            ex(ALU_ADD, 1, 0, 1, 0, 0, 1, 0),
            ex(ALU_A,   0, 0, 0, 0, 1, 0, 0),
            ex(ALU_A,   0, 0, 1, 0, 0, 0, 0),
            ex(ALU_ADD, 0, 0, 1, 0, 0, 1, 0),
            ex(ALU_A,   0, 0, 0, 0, 1, 0, 0),
            ex(ALU_B,   1, 0, 1, 0, 0, 1, 0),
            ex(ALU_A,   0, 0, 1, 0, 0, 0, 0)};
        exp_t it;
        vec_t got;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive($sformatf("flags_branch[%0d]", i), ops[i], afs[i], 1'b0, exps[i]);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
    endtask

    // Second and third ops during the stall are deliberately different and must be ignored.
    task automatic test_mul3();
        logic [5:0] ops[8] = '{OP_MUL, OP_JMP, OP_ADD, OP_NOP, OP_MUL, OP_MUL, OP_MUL, OP_NOP};
        logic [3:0] afs[8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0000,
                               4'b1000, 4'b1000, 4'b1000, 4'b0000};
        logic [9:0] exps[8] = '{
            ex(ALU_MUL, 0, 0, 0, 0, 0, 0, 1),
            ex(ALU_MUL, 0, 0, 0, 0, 0, 0, 1),
            ex(ALU_MUL, 0, 0, 1, 0, 0, 1, 1),
            ex(ALU_A,   0, 0, 1, 0, 0, 1, 0),
            ex(ALU_MUL, 0, 0, 0, 0, 0, 0, 1),
            ex(ALU_MUL, 0, 0, 0, 0, 0, 0, 1),
            ex(ALU_MUL, 0, 0, 1, 0, 0, 1, 1),
            ex(ALU_A,   0, 0, 1, 0, 0, 1, 0)};
        exp_t it;
        vec_t got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive($sformatf("mul3[%0d]", i), ops[i], afs[i], 1'b0, exps[i]);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
    endtask

    task automatic test_back_to_back_mul1();
        logic [5:0] ops[3] = '{OP_MUL, OP_MUL, OP_NOP};
        logic [3:0] afs[3] = '{4'b1001, 4'b0100, 4'b0000};
        logic [9:0] exps[3] = '{
            ex(ALU_MUL, 0, 0, 1, 0, 0, 1, 0),
            ex(ALU_MUL, 0, 0, 1, 0, 0, 1, 0),
            ex(ALU_A,   0, 0, 1, 0, 0, 1, 0)};
        exp_t it;
        vec_t got;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive($sformatf("mul1[%0d]", i), ops[i], afs[i], 1'b0, exps[i]);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(1);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
    endtask

    task automatic test_wait();
        logic [9:0] stall = ex(ALU_A, 0, 0, 0, 0, 0, 0, 1);
        logic [9:0] go = ex(ALU_A, 0, 0, 1, 0, 0, 1, 0);
        int         rel_cyc = 5 + Sync;
        exp_t       it;
        vec_t       got;
        apply_reset();
        // WAIT1 held from cycle 1, switch raised in cycle 5, released Sync edges later.
        for (int i = 1; i <= rel_cyc; i++) begin
            drive($sformatf("wait1_cyc%0d", i), OP_WAIT1, 4'd0, (i >= 5),
                  (i < rel_cyc) ? stall : go);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
        drive("wait1_already", OP_WAIT1, 4'd0, 1'b1, go);
        @(negedge clk);
        it = sb.pop_front();
        got = obs(3);
        n_cmp++;
        if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", it.name, got, it.v);
        end
        for (int i = 0; i <= Sync; i++) begin
            drive($sformatf("wait0_cyc%0d", i), OP_WAIT0, 4'd0, 1'b0, (i < Sync) ? stall : go);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
    endtask

    task automatic test_halt();
        logic [5:0] ops[4] = '{OP_HALT, OP_LDI, OP_JMP, OP_ADD};
        logic [9:0] halted = ex(ALU_A, 0, 0, 0, 0, 0, 0, 1);
        exp_t       it;
        vec_t       got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive($sformatf("halt[%0d]", i), ops[i], 4'hF, 1'b0, halted);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        op = OP_NOP;
        flags_m = 4'd0;
        it.name = "halt_in_reset";
        it.v = '0;
        sb.push_back(it);
        @(negedge clk);
        it = sb.pop_front();
        got = obs(3);
        n_cmp++;
        if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", it.name, got, it.v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive("after_halt_ldi", OP_LDI, 4'd0, 1'b0, ex(ALU_B, 1, 0, 1, 0, 0, 1, 0));
        @(negedge clk);
        it = sb.pop_front();
        got = obs(3);
        n_cmp++;
        if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", it.name, got, it.v);
        end
        drive("after_halt_lds", OP_LDS, 4'd0, 1'b0, ex(ALU_B, 1, 1, 1, 0, 0, 1, 0));
        @(negedge clk);
        it = sb.pop_front();
        got = obs(3);
        n_cmp++;
        if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", it.name, got, it.v);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t it;
        vec_t got;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive($sformatf("mul4[%0d]", i), OP_MUL, 4'hF, 1'b0, ex(ALU_MUL, 0, 0, 0, 0, 0, 0, 1));
            @(negedge clk);
            it = sb.pop_front();
            got = obs(4);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
        // Reset lands mid-cycle of the second MUL_BUSY cycle and spans the would-be write cycle.
        #2;
        rst_n = 1'b0;
        op = OP_NOP;
        flags_m = 4'd0;
        for (int i = 0; i < 4; i++) begin
            it.name = $sformatf("mul4_in_reset[%0d]", i);
            it.v = '0;
            sb.push_back(it);
            if (i == 0) #1;
            else @(negedge clk);
            it = sb.pop_front();
            got = obs(4);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive("mul4_after_reset", OP_NOP, 4'd0, 1'b0, ex(ALU_A, 0, 0, 1, 0, 0, 1, 0));
        @(negedge clk);
        it = sb.pop_front();
        got = obs(4);
        n_cmp++;
        if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", it.name, got, it.v);
        end
    endtask

    // Z=0 and the synchronised switch is 0 for the whole sweep; MUL and HALT are covered elsewhere.
    task automatic test_sweep();
        logic [9:0] e10;
        exp_t       it;
        vec_t       got;
        apply_reset();
        for (int o = 0; o < 64; o++) begin
            if (o == int'(OP_MUL) || o == int'(OP_HALT)) continue;
            case (6'(o))
                OP_ADD:   e10 = ex(ALU_ADD, 0, 0, 1, 0, 0, 1, 0);
                OP_ADDI:  e10 = ex(ALU_ADD, 1, 0, 1, 0, 0, 1, 0);
                OP_LDI:   e10 = ex(ALU_B,   1, 0, 1, 0, 0, 1, 0);
                OP_LDS:   e10 = ex(ALU_B,   1, 1, 1, 0, 0, 1, 0);
                OP_JMP:   e10 = ex(ALU_A,   0, 0, 0, 1, 0, 0, 0);
                OP_BEQ:   e10 = ex(ALU_A,   0, 0, 1, 0, 0, 0, 0);
                OP_BNE:   e10 = ex(ALU_A,   0, 0, 0, 0, 1, 0, 0);
                OP_WAIT1: e10 = ex(ALU_A,   0, 0, 0, 0, 0, 0, 1);
                default:  e10 = ex(ALU_A,   0, 0, 1, 0, 0, 1, 0);
            endcase
            drive($sformatf("sweep_op%0d", o), 6'(o), 4'd0, 1'b0, e10);
            @(negedge clk);
            it = sb.pop_front();
            got = obs(3);
            n_cmp++;
            if (got !== it.v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", it.name, got, it.v);
            end
            n_cmp++;
            if ($countones(got[8:6]) > 1) begin
                n_bad++;
                $display("FAIL sweep_onehot_op%0d: got inc/abs/rel=%b want at most one set",
                         o, got[8:6]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flags_branch();
        test_mul3();
        test_back_to_back_mul1();
        test_wait();
        test_halt();
        test_reset_mid_mul();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_decoder.md
Name: control_decoder

Overview:
Parametrised successor to the picoMIPS single-cycle decoder. It adds a control FSM for multi-cycle MUL stalls, flag-qualified branches, absolute jumps, a HALT state, and a synchronised demo switch for WAIT0/WAIT1. It sits between program memory (opCode) and the ALU/PC/register-file control inputs. It also owns the registered ALU flag set.

Parameters:
O_SIZE, 6, opCode width (cpuConfig::opCode_t; cpuConfig gains BEQ, BNE, JMP, HALT).
A_SIZE, 3, ALU function width (cpuConfig::aluFunc_t).
F_SIZE, 4, ALU flag width; bit0=Z, bit1=C, bit2=V, bit3=N.
MUL_CYCLES, 2, MUL latency in cycles (>=1).
SYNC_STAGES, 2, demoSwitch synchroniser depth (>=2).

Ports:
clk  in  1  system clock
nReset  in  1  asynchronous active-low reset
opCode  in  O_SIZE  current instruction opcode
demoSwitch  in  1  asynchronous board switch
aluFlags  in  F_SIZE  combinational ALU flags for the current cycle
aluFunc  out  A_SIZE  ALU function select
aluImmediate  out  1  ALU B operand = immediate
immSwitches  out  1  immediate sourced from switches
pcInc  out  1  PC increments at next edge
pcBranchAbs  out  1  PC loads immediate (absolute)
pcBranchRel  out  1  PC adds immediate (relative)
writeReg  out  1  register-file write enable
flags  out  F_SIZE  registered flag set
busy  out  1  FSM not in RUN (MUL stall, WAIT, or HALTED)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on nReset. All flops clear on reset: state=RUN, mulCnt=0, flags=0, synchroniser=0.
- While nReset is low, outputs are forced to aluFunc=ALU_A, every 1-bit output=0, and flags=0. The first decode happens in the first cycle after nReset deasserts.
- Defaults every cycle: aluFunc=ALU_A, aluImmediate=0, immSwitches=0, pcInc=1, pcBranchAbs=0, pcBranchRel=0, writeReg=1.
- RUN decode (combinational on opCode):
  - NOP: defaults.
  - LDI: ALU_B, aluImmediate=1.
  - LDS: ALU_B, aluImmediate=1, immSwitches=1.
  - ADD: ALU_ADD.
  - ADDI: ALU_ADD, aluImmediate=1.
  - JMP: pcBranchAbs=1, pcInc=0, writeReg=0.
  - BEQ: writeReg=0. If flags[0]=1 then pcBranchRel=1, pcInc=0; otherwise pcInc=1.
  - BNE: as BEQ with the condition inverted.
  - Undefined opcodes behave as NOP.
- MUL:
  - If MUL_CYCLES=1: single cycle, aluFunc=ALU_MUL, writeReg=1, pcInc=1.
  - Otherwise: RUN->MUL_BUSY with mulCnt=MUL_CYCLES-1. In that entry cycle, aluFunc=ALU_MUL, pcInc=0, writeReg=0.
  - In MUL_BUSY, aluFunc=ALU_MUL is held and mulCnt decrements each cycle. When mulCnt==1, writeReg=1 and pcInc=1, and the next state is RUN.
  - Total latency is MUL_CYCLES cycles, with exactly one write.
  - opCode changes during MUL_BUSY are ignored.
- WAIT0/WAIT1:
  - The switch is sampled via the SYNC_STAGES-flop synchroniser; swSync is the final stage.
  - writeReg=0 and pcInc=0 until the condition holds (swSync==0 for WAIT0, swSync==1 for WAIT1).
  - The condition is evaluated in the same cycle the opcode is presented; if it already holds, pcInc=1 with no stall.
  - State is WAIT while stalled, RUN otherwise; busy=1 while stalled.
- HALT: next state HALTED. In HALTED, pcInc=0, writeReg=0, no branches, busy=1. HALTED exits only via reset.
- Flags:
  - flags <= aluFlags at the edge of any cycle where writeReg=1 and aluFunc is ALU_ADD or ALU_MUL.
  - Loads (LDI/LDS) do not update flags.
  - A branch tests registered flags only, never the same-cycle aluFlags.
- pcBranchAbs, pcBranchRel and pcInc are mutually exclusive in every cycle (assertion required).
- Reset mid-MUL or mid-WAIT returns to RUN with no write issued.

Test Plan:
1. Reset, then ADDI with aluFlags=4'b0001, then BEQ. Required: ADDI gives writeReg=1 and aluImmediate=1; flags=0001 the next cycle; BEQ gives pcBranchRel=1, pcInc=0, writeReg=0. BNE in the same position gives pcInc=1.
2. MUL_CYCLES=3, MUL held for 3 cycles.
   - Cycles 1 and 2: pcInc=0, writeReg=0, busy=1.
   - Cycle 3: writeReg=1, pcInc=1.
   - Cycle 4: busy=0.
   - Repeat with MUL_CYCLES=1: single-cycle write.
3. WAIT1 with demoSwitch=0, toggled to 1 at cycle 5. Required: pcInc=0 and writeReg=0 until exactly SYNC_STAGES edges after the toggle, then pcInc=1 for one cycle.
4. HALT followed by LDI and JMP. Required: pcInc=0, writeReg=0, busy=1 for every cycle. Asserting nReset low clears the state; after release, LDI decodes normally.
5. nReset asserted asynchronously in MUL_BUSY cycle 2 (MUL_CYCLES=4). Required: outputs clear immediately, no writeReg pulse, and state=RUN after release.
6. Sweep every opCode value in RUN. Required: the branch/inc one-hot holds, and undefined opcodes produce the NOP outputs.
